// File: rtl/life_ctrl_16x16.sv
`default_nettype none
// ============================================================================
// Module      : life_ctrl_16x16
// Description : Sequencer for a 16x16 life array. Streams a 16-row initial
//               pattern into the array, then repeats scan-out / wait / step
//               generations until stopped. Optional still-life auto-halt is
//               compiled in when LIFE_STABLE_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module life_ctrl_16x16 #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [COLS-1:0]          ld_row,
    input  logic                     start,
    input  logic                     stop,
    input  logic [CNT_W-1:0]         period,
    output logic [COLS-1:0]          arr_vali,
    output logic [$clog2(ROWS)-1:0]  arr_vali_sel,
    output logic                     arr_write_enb,
    output logic                     arr_step,
    output logic [$clog2(ROWS)-1:0]  arr_valo_sel,
    input  logic [COLS-1:0]          arr_valo,
    input  logic [COLS-1:0]          arr_valo_prev,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS-1:0]          out_row,
    output logic [$clog2(ROWS)-1:0]  out_row_idx,
    output logic                     out_last,
    output logic [CNT_W-1:0]         gen_count,
    output logic                     busy,
    output logic                     stable
);

    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] C_LAST_ROW = IDX_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SCAN   = 3'd2,
        S_WAIT   = 3'd3,
        S_STEP   = 3'd4,
        S_SETTLE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_load_idx;
    logic [IDX_W-1:0]   r_scan_idx;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_loaded;
    logic               r_stop_pending;

    logic w_ld_acc;
    logic w_out_hs;
    logic w_scan_done;
    logic w_stop_req;
    logic w_start_run;
    logic w_stable_hit;

    assign w_ld_acc    = ld_valid & ld_ready;
    assign w_out_hs    = out_valid & out_ready;
    assign w_scan_done = w_out_hs & (r_scan_idx == C_LAST_ROW);
    // A stop seen in the same cycle as the decision point counts immediately
    assign w_stop_req  = r_stop_pending | stop;
    // Load beats take priority over start in IDLE
    assign w_start_run = (r_state == S_IDLE) & ~ld_valid & start & r_loaded;

`ifdef LIFE_STABLE_DETECT_EN
    logic r_match;

    // Still-life hit: every row of this scan equals the previous generation
    assign w_stable_hit = w_scan_done & r_match & (arr_valo == arr_valo_prev)
                        & (gen_count != '0);

    // Accumulate the per-row comparison and hold the stable flag until restart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match <= 1'b1;
            stable  <= 1'b0;
        end else begin
            if (r_state != S_SCAN || w_scan_done)
                r_match <= 1'b1;
            else if (w_out_hs)
                r_match <= r_match & (arr_valo == arr_valo_prev);
            if ((r_state == S_IDLE) && (ld_valid || w_start_run))
                stable <= 1'b0;
            else if (w_stable_hit)
                stable <= 1'b1;
        end
    end
`else
    logic w_unused_prev;
    assign w_unused_prev = ^arr_valo_prev;
    assign w_stable_hit  = 1'b0;
    assign stable        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next       = r_state;
        ld_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        arr_step     = 1'b0;
        busy         = (r_state != S_IDLE);
        out_row      = arr_valo;
        out_row_idx  = r_scan_idx;
        arr_valo_sel = r_scan_idx;
        case (r_state)
            S_IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid)
                    w_next = S_LOAD;
                else if (w_start_run)
                    w_next = S_SCAN;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && (r_load_idx == C_LAST_ROW))
                    w_next = S_IDLE;
            end
            S_SCAN: begin
                out_valid = 1'b1;
                out_last  = (r_scan_idx == C_LAST_ROW);
                if (w_scan_done)
                    w_next = (w_stop_req || w_stable_hit) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (w_stop_req)
                    w_next = S_IDLE;
                else if (r_wait_cnt <= CNT_W'(1))
                    w_next = S_STEP;
            end
            S_STEP: begin
                arr_step = 1'b1;
                w_next   = S_SETTLE;
            end
            S_SETTLE: w_next = S_SCAN;
            default:  w_next = S_IDLE;
        endcase
    end

    // Array write port, load/scan indices, wait timer, flags and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arr_vali       <= '0;
            arr_vali_sel   <= '0;
            arr_write_enb  <= 1'b0;
            r_load_idx     <= '0;
            r_scan_idx     <= '0;
            r_wait_cnt     <= '0;
            r_loaded       <= 1'b0;
            r_stop_pending <= 1'b0;
            gen_count      <= '0;
        end else begin
            arr_write_enb <= w_ld_acc;
            if (w_ld_acc) begin
                arr_vali <= ld_row;
                if (r_state == S_IDLE) begin
                    arr_vali_sel <= '0;
                    r_load_idx   <= IDX_W'(1);
                    r_loaded     <= 1'b0;
                    gen_count    <= '0;
                end else begin
                    arr_vali_sel <= r_load_idx;
                    r_load_idx   <= r_load_idx + IDX_W'(1);
                    if (r_load_idx == C_LAST_ROW)
                        r_loaded <= 1'b1;
                end
            end
            if (w_start_run) begin
                r_stop_pending <= 1'b0;
                r_scan_idx     <= '0;
            end
            if ((r_state != S_IDLE) && (r_state != S_LOAD) && stop)
                r_stop_pending <= 1'b1;
            if ((r_state == S_SCAN) && w_out_hs)
                r_scan_idx <= r_scan_idx + IDX_W'(1);
            // Period is captured once per generation; zero behaves as one
            if ((r_state == S_SCAN) && w_scan_done)
                r_wait_cnt <= (period == '0) ? CNT_W'(1) : period;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            if (r_state == S_STEP)
                gen_count <= gen_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_life_ctrl_16x16.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_ctrl_16x16
// Description : Directed bench for life_ctrl_16x16 with a behavioural 16x16
//               life array. A second instance with a 4-bit generation
//               counter exercises counter wrap in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_ctrl_16x16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_row = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = '0;
    logic        out_ready = 1'b0;

    logic        ld_ready, arr_write_enb, arr_step, out_valid, out_last, busy, stable;
    logic [15:0] arr_vali, arr_valo, arr_valo_prev, out_row, gen_count;
    logic [3:0]  arr_vali_sel, arr_valo_sel, out_row_idx;

    logic        s_ld_ready, s_arr_write_enb, s_arr_step, s_out_valid, s_out_last;
    logic        s_busy, s_stable;
    logic [15:0] s_arr_vali, s_out_row;
    logic [3:0]  s_arr_vali_sel, s_arr_valo_sel, s_out_row_idx, s_gen_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mem [16];
    logic [15:0] prv [16];
    logic [15:0] nxt [16];
    logic [15:0] pat [16];
    logic [15:0] expr [16];

    always #5 clk = ~clk;

    life_ctrl_16x16 u_dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_row(ld_row), .start(start), .stop(stop), .period(period),
        .arr_vali(arr_vali), .arr_vali_sel(arr_vali_sel),
        .arr_write_enb(arr_write_enb), .arr_step(arr_step),
        .arr_valo_sel(arr_valo_sel), .arr_valo(arr_valo),
        .arr_valo_prev(arr_valo_prev), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx),
        .out_last(out_last), .gen_count(gen_count), .busy(busy), .stable(stable)
    );

    life_ctrl_16x16 #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(s_ld_ready),
        .ld_row(ld_row), .start(start), .stop(stop), .period(period[3:0]),
        .arr_vali(s_arr_vali), .arr_vali_sel(s_arr_vali_sel),
        .arr_write_enb(s_arr_write_enb), .arr_step(s_arr_step),
        .arr_valo_sel(s_arr_valo_sel), .arr_valo(16'h0000),
        .arr_valo_prev(16'hFFFF), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_row(s_out_row), .out_row_idx(s_out_row_idx),
        .out_last(s_out_last), .gen_count(s_gen_count), .busy(s_busy),
        .stable(s_stable)
    );

    // Behavioural array: next generation with dead borders
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            nxt[r] = '0;
            for (int c = 0; c < 16; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < 16)
                            && (c + dc >= 0) && (c + dc < 16))
                            n += int'(mem[r + dr][c + dc]);
                nxt[r][c] = (n == 3) || (mem[r][c] && (n == 2));
            end
        end
    end

    initial begin
        for (int r = 0; r < 16; r++) begin
            mem[r] = '0;
            prv[r] = '0;
        end
    end

    // Array storage: row writes and generation steps
    always @(posedge clk) begin
        if (arr_write_enb) mem[arr_vali_sel] <= arr_vali;
        if (arr_step) begin
            for (int r = 0; r < 16; r++) begin
                prv[r] <= mem[r];
                mem[r] <= nxt[r];
            end
        end
    end

    assign arr_valo      = mem[arr_valo_sel];
    assign arr_valo_prev = prv[arr_valo_sel];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_pat();
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_row   = pat[i];
            check($sformatf("ld_ready_%0d", i), ld_ready, 1);
            tick();
            check($sformatf("wr_en_%0d", i), arr_write_enb, 1);
            check($sformatf("wr_sel_%0d", i), arr_vali_sel, i);
            check($sformatf("wr_data_%0d", i), arr_vali, pat[i]);
        end
        ld_valid = 1'b0;
    endtask

    // Expects out_valid already high; out_ready held at 1
    task automatic scan_rows(input string tag, input int stop_at);
        for (int r = 0; r < 16; r++) begin
            if (r == stop_at) stop = 1'b1;
            check($sformatf("%s_valid_%0d", tag, r), out_valid, 1);
            check($sformatf("%s_idx_%0d", tag, r), out_row_idx, r);
            check($sformatf("%s_row_%0d", tag, r), out_row, expr[r]);
            check($sformatf("%s_last_%0d", tag, r), out_last, (r == 15) ? 1 : 0);
            tick();
        end
    endtask

    initial begin
        int steps;
        int e;
        int last_c;

        // ---- reset values
        tick(); tick();
        check("rst_wr_en", arr_write_enb, 0);
        check("rst_vali", arr_vali, 0);
        check("rst_sel", arr_vali_sel, 0);
        check("rst_step", arr_step, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_row_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_gen", gen_count, 0);
        check("rst_busy", busy, 0);
        check("rst_stable", stable, 0);
        check("rst_ld_ready", ld_ready, 1);
        reset = 1'b0;
        tick();

        // ---- start before any load must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_unloaded_busy", busy, 0);

        // ---- walking-one load
        for (int i = 0; i < 16; i++) pat[i] = 16'h0001 << i;
        load_pat();
        check("load_done_busy", busy, 0);
        tick();
        check("load_done_wr_en", arr_write_enb, 0);

        // ---- blinker, period 3
        for (int i = 0; i < 16; i++) pat[i] = '0;
        pat[7] = 16'h0380;
        load_pat();
        period    = 16'd3;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) expr[i] = pat[i];
        scan_rows("g0", -1);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("wait_nostep_%0d", k), arr_step, 0);
            check($sformatf("wait_busy_%0d", k), busy, 1);
            tick();
        end
        check("step_pulse", arr_step, 1);
        tick();
        check("settle_valid", out_valid, 0);
        check("gen_after_step", gen_count, 1);
        tick();
        for (int i = 0; i < 16; i++) expr[i] = '0;
        expr[6] = 16'h0100; expr[7] = 16'h0100; expr[8] = 16'h0100;
        scan_rows("g1", 5);
        stop = 1'b0;
        check("stop_scan_busy", busy, 0);
        check("stop_scan_valid", out_valid, 0);
        steps = 0;
        for (int k = 0; k < 8; k++) begin
            if (arr_step) steps++;
            tick();
        end
        check("stop_no_step", steps, 0);

        // ---- backpressure, then stop in WAIT
        period = 16'd10;
        start  = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        for (int c = 0; c < 80 && e < 16; c++) begin
            out_ready = (c % 2 == 0);
            check($sformatf("bp_valid_%0d", c), out_valid, 1);
            check($sformatf("bp_idx_%0d", c), out_row_idx, e);
            check($sformatf("bp_row_%0d", c), out_row, expr[e]);
            check($sformatf("bp_last_%0d", c), out_last, (e == 15) ? 1 : 0);
            if (out_ready) e++;
            tick();
        end
        check("bp_rows_seen", e, 16);
        out_ready = 1'b1;
        tick(); tick();
        check("wait_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_wait_idle", busy, 0);
        check("stop_wait_gen", gen_count, 1);

        // ---- period 0: one-cycle WAIT; 15 more steps wrap the 4-bit counter
        period = 16'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        steps  = 0;
        last_c = -100;
        for (int c = 0; c < 1000 && busy; c++) begin
            if (out_valid && out_last) last_c = c;
            if (arr_step) begin
                steps++;
                if (steps == 1) check("p0_step_delay", c - last_c, 2);
                if (steps == 15) stop = 1'b1;
            end
            tick();
        end
        stop = 1'b0;
        check("p0_halted", busy, 0);
        check("p0_steps", steps, 15);
        check("p0_gen16", gen_count, 16);
        check("p0_gen4_wrap", s_gen_count, 0);

        // ---- still life (2x2 block)
        for (int i = 0; i < 16; i++) pat[i] = '0;
        pat[4] = 16'h0030; pat[5] = 16'h0030;
        load_pat();
        check("block_gen_clr", gen_count, 0);
        period = 16'd2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        steps = 0;
        for (int c = 0; c < 400 && busy; c++) begin
            if (arr_step) steps++;
`ifndef LIFE_STABLE_DETECT_EN
            if (steps == 3) stop = 1'b1;
`endif
            tick();
        end
        stop = 1'b0;
        check("block_halted", busy, 0);
`ifdef LIFE_STABLE_DETECT_EN
        check("block_stable", stable, 1);
        check("block_steps", steps, 1);
        check("block_gen", gen_count, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("block_stable_clr", stable, 0);
        stop = 1'b1;
        for (int c = 0; c < 100 && busy; c++) tick();
        stop = 1'b0;
        check("block_restop", busy, 0);
`else
        check("block_stable", stable, 0);
        check("block_steps", steps, 3);
        check("block_gen", gen_count, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
